// File: rtl/sd_rrmux_pkt.sv
`default_nettype none
// ============================================================================
// Module   : sd_rrmux_pkt
// Purpose  : Round-robin srdy/drdy multiplexer with a registered output stage
//            and optional per-packet grant lock.
// Revision : 1.0  initial release
// ============================================================================
module sd_rrmux_pkt #(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int mode   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    input  logic [inputs-1:0]       c_eop,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic [inputs-1:0]       p_grant
);
    localparam int IW = (inputs > 1) ? $clog2(inputs) : 1;
    localparam logic [IW-1:0] LAST_RESET = IW'(inputs - 1);

    logic [IW-1:0]     last;
    logic [IW-1:0]     lock_id;
    logic              locked;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     cand;
    logic              sel_valid;
    logic              load_en;
    logic              xfer;
    logic [inputs-1:0] sel_onehot;

    assign load_en = !p_srdy || p_drdy;

    // Scan farthest-first so the requester nearest to last+1 is the final writer.
    always_comb begin
        sel       = last;
        sel_valid = 1'b0;
        cand      = '0;
        if (locked) begin
            sel       = lock_id;
            sel_valid = c_srdy[lock_id];
        end else begin
            for (int i = inputs; i >= 1; i--) begin
                cand = IW'((int'(last) + i) % inputs);
                if (c_srdy[cand]) begin
                    sel       = cand;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign xfer   = sel_valid && load_en;
    assign c_drdy = xfer ? sel_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_srdy  <= 1'b0;
            p_data  <= '0;
            p_grant <= '0;
            last    <= LAST_RESET;
            locked  <= 1'b0;
            lock_id <= '0;
        end else begin
            if (xfer) begin
                p_data  <= c_data[int'(sel)*width +: width];
                p_grant <= sel_onehot;
                p_srdy  <= 1'b1;
                last    <= sel;
                if (mode == 1) begin
                    locked <= !c_eop[sel];
                    if (!c_eop[sel])
                        lock_id <= sel;
                end
            end else if (p_drdy) begin
                p_srdy  <= 1'b0;
                p_grant <= '0;
            end
        end
    end
endmodule
`default_nettype wire
